// File: rtl/mult_fix_seq_32_8.sv
// Sequential fixed-point multiplier: saturating (A * B) >> FRAC_B with B in UQ1.7.
// One multiplier bit per cycle (shift-add), eight CALC cycles per operand pair.
module mult_fix_seq_32_8 #(
  parameter int unsigned DATAWIDTH_IN  = 32,
  parameter int unsigned DATAWIDTH_OUT = 32,
  parameter int unsigned FRAC_B        = 7
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_a_tvalid,
  input  logic [DATAWIDTH_IN-1:0]  s_axis_a_tdata,
  input  logic                     s_axis_b_tvalid,
  input  logic [7:0]               s_axis_b_tdata,
  output logic                     s_axis_tready,
  output logic                     m_axis_result_tvalid,
  output logic [DATAWIDTH_OUT-1:0] m_axis_result_tdata,
  output logic                     m_axis_result_tuser
);

  localparam int unsigned ACC_W = DATAWIDTH_IN + 8;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   a_q;
  logic [7:0]         b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [2:0]         count_q;

  logic               accept;
  logic               last;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   prod_shift;
  logic               overflow;

  assign s_axis_tready = (state_q == IDLE);
  assign accept        = s_axis_tready && s_axis_a_tvalid && s_axis_b_tvalid;
  assign last          = (count_q == 3'd7);

  // The final partial product is folded in combinationally so the result
  // is registered on the same edge that completes the eighth step.
  always_comb begin
    addend     = b_q[count_q] ? (a_q << count_q) : '0;
    acc_next   = acc_q + addend;
    prod_shift = acc_next >> FRAC_B;
    overflow   = |prod_shift[ACC_W-1:DATAWIDTH_OUT];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      a_q                  <= '0;
      b_q                  <= '0;
      acc_q                <= '0;
      count_q              <= '0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      m_axis_result_tuser  <= 1'b0;
    end else begin
      m_axis_result_tvalid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= {{(ACC_W-DATAWIDTH_IN){1'b0}}, s_axis_a_tdata};
            b_q     <= s_axis_b_tdata;
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        CALC: begin
          acc_q   <= acc_next;
          count_q <= count_q + 3'd1;
          if (last) begin
            m_axis_result_tvalid <= 1'b1;
            m_axis_result_tuser  <= overflow;
            m_axis_result_tdata  <= overflow ? '1 : prod_shift[DATAWIDTH_OUT-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_fix_seq_32_8.sv
// Scoreboard bench for mult_fix_seq_32_8: directed vectors with hand-computed
// products; a negedge monitor checks data, overflow flag and result timing.
module tb_mult_fix_seq_32_8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axis_a_tvalid = 1'b0;
  logic [31:0] s_axis_a_tdata = '0;
  logic        s_axis_b_tvalid = 1'b0;
  logic [7:0]  s_axis_b_tdata = '0;
  logic        s_axis_tready;
  logic        m_axis_result_tvalid;
  logic [31:0] m_axis_result_tdata;
  logic        m_axis_result_tuser;

  mult_fix_seq_32_8 #(
    .DATAWIDTH_IN (32),
    .DATAWIDTH_OUT(32),
    .FRAC_B       (7)
  ) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .s_axis_a_tvalid     (s_axis_a_tvalid),
    .s_axis_a_tdata      (s_axis_a_tdata),
    .s_axis_b_tvalid     (s_axis_b_tvalid),
    .s_axis_b_tdata      (s_axis_b_tdata),
    .s_axis_tready       (s_axis_tready),
    .m_axis_result_tvalid(m_axis_result_tvalid),
    .m_axis_result_tdata (m_axis_result_tdata),
    .m_axis_result_tuser (m_axis_result_tuser)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic        user;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge aclk) begin
    if (aresetn && m_axis_result_tvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data %h user %0b, expected no result (cycle %0d)",
                 m_axis_result_tdata, m_axis_result_tuser, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_data", m_axis_result_tdata, e.data);
        chk("result_user", {31'd0, m_axis_result_tuser}, {31'd0, e.user});
        chk("result_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge: drives one pair for the next rising edge, then releases.
  task automatic present(input logic [31:0] a, input logic [7:0] b, input bit push,
                         input logic [31:0] ed, input logic eu);
    s_axis_a_tvalid = 1'b1;
    s_axis_a_tdata  = a;
    s_axis_b_tvalid = 1'b1;
    s_axis_b_tdata  = b;
    if (push) sb.push_back('{data: ed, user: eu, due: cyc + 9});
    @(negedge aclk);
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [7:0] b,
                         input logic [31:0] ed, input logic eu);
    present(a, b, 1'b1, ed, eu);
    repeat (9) @(negedge aclk);
  endtask

  initial begin
    #2;
    chk("reset_tvalid", {31'd0, m_axis_result_tvalid}, 32'd0);
    chk("reset_tdata", m_axis_result_tdata, 32'd0);
    chk("reset_tready", {31'd0, s_axis_tready}, 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;

    run_one(32'h1000_0000, 8'h80, 32'h1000_0000, 1'b0);
    run_one(32'h0000_0064, 8'h40, 32'h0000_0032, 1'b0);
    run_one(32'h0000_0003, 8'h01, 32'h0000_0000, 1'b0);
    run_one(32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 1'b1);
    run_one(32'hFFFF_FFFF, 8'h80, 32'hFFFF_FFFF, 1'b0);
    run_one(32'hFFFF_FFFF, 8'h00, 32'h0000_0000, 1'b0);
    run_one(32'h1234_5678, 8'hC0, 32'h1B4E_81B4, 1'b0);
    run_one(32'hAAAA_AAAA, 8'hC0, 32'hFFFF_FFFF, 1'b0);
    run_one(32'hAAAA_AAAB, 8'hC0, 32'hFFFF_FFFF, 1'b1);

    // Busy drop and back-to-back accept.
    present(32'd5, 8'h80, 1'b1, 32'd5, 1'b0);
    repeat (2) @(negedge aclk);
    chk("busy_tready", {31'd0, s_axis_tready}, 32'd0);
    present(32'd7, 8'h80, 1'b0, 32'd0, 1'b0);
    repeat (5) @(negedge aclk);
    chk("b2b_tready", {31'd0, s_axis_tready}, 32'd1);
    present(32'd9, 8'h80, 1'b1, 32'd9, 1'b0);
    repeat (10) @(negedge aclk);

    // Half-valid pairs are never accepted.
    s_axis_a_tvalid = 1'b1;
    s_axis_a_tdata  = 32'h0000_0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("half_valid_tready", {31'd0, s_axis_tready}, 32'd1);
    end
    s_axis_a_tvalid = 1'b0;
    s_axis_b_tvalid = 1'b1;
    s_axis_b_tdata  = 8'h80;
    @(negedge aclk);
    chk("half_valid_b_tready", {31'd0, s_axis_tready}, 32'd1);
    s_axis_b_tvalid = 1'b0;
    repeat (10) @(negedge aclk);

    // Mid-calculation reset: outputs clear immediately, in-flight op is lost.
    present(32'h0000_0100, 8'h80, 1'b0, 32'd0, 1'b0);
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("midreset_tvalid", {31'd0, m_axis_result_tvalid}, 32'd0);
    chk("midreset_tdata", m_axis_result_tdata, 32'd0);
    chk("midreset_tuser", {31'd0, m_axis_result_tuser}, 32'd0);
    chk("midreset_tready", {31'd0, s_axis_tready}, 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (12) @(negedge aclk);

    run_one(32'h0000_0080, 8'h81, 32'h0000_0081, 1'b0);
    repeat (2) @(negedge aclk);
    chk("missing_results", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
